writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
- Registered, parametrised writeback stage for the RISC-V pipeline; successor to the combinational result mux.
- Accepts retiring instructions from MEM with a valid/ready handshake and selects the result among ALU, load data, PC+4 and CSR.
- Stalls on loads until the data-memory read response arrives, then performs sub-word alignment and sign/zero extension.
- Drives the register-file write port and a retired-instruction counter.

Parameters:
- DATA_W, 32: datapath width; only 32 is supported for the load-extension path.
- REG_ADDR_W, 5: register index width.
- CNT_W, 32: retire counter width.
- X0_HARDWIRED, 1: when 1, writes to rd==0 are suppressed.

Ports:
- clk  in  1  clock; one clock; reset is asynchronous and active-low
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  cancel the in-flight load and drop the same-cycle input
- in_valid  in  1  MEM presents an instruction
- in_ready  out  1  stage can accept
- result_set  in  2  00 ALU, 01 memory, 10 PC+4, 11 CSR
- alu_result  in  DATA_W  ALU result; low 2 bits are the load byte offset
- pc_plus4  in  DATA_W  link value
- csr_data  in  DATA_W  CSR read value
- load_funct3  in  3  load type
- rd  in  REG_ADDR_W  destination register
- reg_write  in  1  instruction writes rd
- mem_rvalid  in  1  read response valid
- mem_rdata  in  DATA_W  raw 32-bit read word
- rf_we  out  1  register-file write enable (one-cycle pulse)
- rf_waddr  out  REG_ADDR_W  write address
- rf_wdata  out  DATA_W  write data
- retire_count  out  CNT_W  retired instruction count

Behaviour:
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, retire_count=0, state=IDLE.
- in_ready=1 in IDLE only. Reset asserted mid-load returns the stage to IDLE; any late mem_rvalid is ignored.
- FSM has two states, IDLE and WAIT_MEM.
- IDLE, in_valid & !flush, result_set != 01:
  - Next cycle: rf_we=reg_write & !(X0_HARDWIRED & rd==0), rf_waddr=rd, rf_wdata=selected value.
  - retire_count increments in that same cycle, regardless of rf_we.
  - Throughput is 1 instruction per cycle.
- IDLE, in_valid & !flush, result_set == 01:
  - Capture rd, reg_write, funct3 and alu_result[1:0]; go to WAIT_MEM.
  - rf_we=0 next cycle.
- WAIT_MEM, mem_rvalid & !flush:
  - Next cycle: rf_we (gated as above) with the extended data; retire_count increments; return to IDLE.
  - Latency from mem_rvalid to rf_we is 1 cycle.
  - A new instruction can be accepted on the cycle rf_we is high.
- mem_rvalid in IDLE is ignored.
- flush in WAIT_MEM: return to IDLE with no write and no retire.
- flush in IDLE: the input is not accepted and no write occurs.
- flush and mem_rvalid in the same cycle: flush wins.
- rf_we is a single-cycle pulse; rf_waddr and rf_wdata hold their last values when rf_we=0.
- Load extension (off = captured alu_result[1:0]):
  - 000 LB: sign-extend byte[off].
  - 100 LBU: zero-extend byte[off].
  - 001 LH: sign-extend half[off[1]].
  - 101 LHU: zero-extend half[off[1]].
  - 010 LW: full word.
  - Other codes: treated as LW.
  - Misaligned halfword/word offsets are not trapped: LH/LHU use off[1] only; LW ignores off.
- retire_count wraps modulo 2^CNT_W.

Test Plan:
- ALU op, rd=5, reg_write=1, alu_result=0x0000_1234 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, retire_count=1.
- Back-to-back: JAL (result_set=10, pc_plus4=0x104, rd=1), then CSR read (csr_data=0xDEAD_BEEF, rd=2) -> rf_we high on two consecutive cycles with those values; in_ready stays 1.
- LB, alu_result=0x...03, mem_rvalid 3 cycles later with mem_rdata=0x80FF_0000 -> in_ready=0 while waiting; one cycle after mem_rvalid rf_wdata=0xFFFF_FF80; for LBU the same stimulus gives 0x0000_0080; for LHU with offset 2 it gives 0x0000_80FF.
- Write to rd=0 with reg_write=1 -> rf_we=0, retire_count increments; reg_write=0 gives the same result.
- Load pending, flush asserted in the same cycle as mem_rvalid -> no rf_we, retire_count unchanged, in_ready=1 next cycle; rst_n pulsed low mid-load -> all outputs zero, stage in IDLE.
- Preload retire_count to 2^CNT_W-1 via 2^CNT_W-1 retirements (use CNT_W=4, 15 ops), then one more retirement -> retire_count=0.

Source files
------------

// File: rtl/writeback_unit.sv
// Registered writeback stage: selects ALU / load / PC+4 / CSR result and drives the register-file write port.
// Latency: one cycle from accept (non-load) or from mem_rvalid (load) to the rf_we pulse.
// Backpressure: in_ready drops while a load waits for its read response; flush cancels the wait and drops the input.
module writeback_unit #(
    parameter int DATA_W       = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int CNT_W        = 32,
    parameter bit X0_HARDWIRED = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            result_set,
    input  logic [DATA_W-1:0]     alu_result,
    input  logic [DATA_W-1:0]     pc_plus4,
    input  logic [DATA_W-1:0]     csr_data,
    input  logic [2:0]            load_funct3,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  reg_write,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic [CNT_W-1:0]      retire_count
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic                  rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]     rf_wdata_q, rf_wdata_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    // Load context captured at accept time, consumed when the response arrives.
    logic [REG_ADDR_W-1:0] ld_rd_q, ld_rd_d;
    logic                  ld_we_q, ld_we_d;
    logic [2:0]            ld_f3_q, ld_f3_d;
    logic [1:0]            ld_off_q, ld_off_d;

    logic [DATA_W-1:0]     sel_data;
    logic [DATA_W-1:0]     load_data;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic                  acc_we;
    logic                  ld_gated_we;

    // Non-load result mux; result_set 01 never reaches this path.
    always_comb begin
        sel_data = alu_result;
        case (result_set)
            2'b10:   sel_data = pc_plus4;
            2'b11:   sel_data = csr_data;
            default: sel_data = alu_result;
        endcase
    end

    // Sub-word alignment and extension of the read word; half select uses off[1] only.
    always_comb begin
        ld_byte   = mem_rdata[{ld_off_q, 3'b000} +: 8];
        ld_half   = mem_rdata[{ld_off_q[1], 4'b0000} +: 16];
        load_data = mem_rdata;
        case (ld_f3_q)
            3'b000:  load_data = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
            3'b100:  load_data = {{(DATA_W-8){1'b0}}, ld_byte};
            3'b001:  load_data = {{(DATA_W-16){ld_half[15]}}, ld_half};
            3'b101:  load_data = {{(DATA_W-16){1'b0}}, ld_half};
            default: load_data = mem_rdata;
        endcase
    end

    // Write-enable gating: x0 writes are dropped when the zero register is hardwired.
    always_comb begin
        acc_we      = reg_write & ~(X0_HARDWIRED && (rd == '0));
        ld_gated_we = ld_we_q   & ~(X0_HARDWIRED && (ld_rd_q == '0));
    end

    // Next-state and output computation for the IDLE / WAIT_MEM controller.
    always_comb begin
        state_d    = state_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        cnt_d      = cnt_q;
        ld_rd_d    = ld_rd_q;
        ld_we_d    = ld_we_q;
        ld_f3_d    = ld_f3_q;
        ld_off_d   = ld_off_q;
        in_ready   = (state_q == IDLE);

        case (state_q)
            IDLE: begin
                if (in_valid && !flush) begin
                    if (result_set == 2'b01) begin
                        ld_rd_d  = rd;
                        ld_we_d  = reg_write;
                        ld_f3_d  = load_funct3;
                        ld_off_d = alu_result[1:0];
                        state_d  = WAIT_MEM;
                    end else begin
                        rf_we_d = acc_we;
                        if (acc_we) begin
                            rf_waddr_d = rd;
                            rf_wdata_d = sel_data;
                        end
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            WAIT_MEM: begin
                // flush has priority over a same-cycle response
                if (flush) begin
                    state_d = IDLE;
                end else if (mem_rvalid) begin
                    rf_we_d = ld_gated_we;
                    if (ld_gated_we) begin
                        rf_waddr_d = ld_rd_q;
                        rf_wdata_d = load_data;
                    end
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, output and load-context registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            cnt_q      <= '0;
            ld_rd_q    <= '0;
            ld_we_q    <= 1'b0;
            ld_f3_q    <= '0;
            ld_off_q   <= '0;
        end else begin
            state_q    <= state_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            cnt_q      <= cnt_d;
            ld_rd_q    <= ld_rd_d;
            ld_we_q    <= ld_we_d;
            ld_f3_q    <= ld_f3_d;
            ld_off_q   <= ld_off_d;
        end
    end

    assign rf_we        = rf_we_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign retire_count = cnt_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: table vectors, load/flush/reset sequences, counter wrap, random traffic vs. a reference model.
// Latency: outputs checked 1 time unit after each rising edge.
// Backpressure: the model tracks whether a load is pending and predicts in_ready.
module tb_writeback_unit;

    localparam int CW = 4;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  result_set;
    logic [31:0] alu_result;
    logic [31:0] pc_plus4;
    logic [31:0] csr_data;
    logic [2:0]  load_funct3;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [CW-1:0] retire_count;

    writeback_unit #(
        .DATA_W(32), .REG_ADDR_W(5), .CNT_W(CW), .X0_HARDWIRED(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .result_set(result_set), .alu_result(alu_result), .pc_plus4(pc_plus4), .csr_data(csr_data),
        .load_funct3(load_funct3), .rd(rd), .reg_write(reg_write), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .retire_count(retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Reference model: pending-load record plus the architectural outputs.
    bit          m_busy;
    int unsigned m_rd, m_f3, m_off;
    bit          m_we;
    bit          m_rf_we;
    int unsigned m_waddr, m_wdata, m_cnt;

    typedef struct {
        logic [1:0]  rs;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [31:0] csr;
        logic [4:0]  rdi;
        logic        rw;
        logic        exp_we;
        logic [4:0]  exp_waddr;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned extend(int unsigned w, int unsigned f3, int unsigned off);
        int unsigned b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            0:       return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
            4:       return b;
            1:       return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
            5:       return h;
            default: return w;
        endcase
    endfunction

    task automatic m_write(input bit we, input int unsigned a, input int unsigned v);
        if (we && a != 0) begin
            m_rf_we = 1;
            m_waddr = a;
            m_wdata = v;
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_rd = 0; m_f3 = 0; m_off = 0; m_we = 0;
        m_rf_we = 0; m_waddr = 0; m_wdata = 0; m_cnt = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        int unsigned v;
        m_rf_we = 0;
        if (!m_busy) begin
            if (in_valid && !flush) begin
                if (result_set == 2'b01) begin
                    m_busy = 1; m_rd = rd; m_we = reg_write; m_f3 = load_funct3; m_off = alu_result % 4;
                end else begin
                    v = (result_set == 2'b00) ? alu_result : (result_set == 2'b10) ? pc_plus4 : csr_data;
                    m_write(reg_write, rd, v);
                    m_cnt = (m_cnt + 1) % (1 << CW);
                end
            end
        end else if (flush) begin
            m_busy = 0;
        end else if (mem_rvalid) begin
            m_write(m_we, m_rd, extend(mem_rdata, m_f3, m_off));
            m_cnt  = (m_cnt + 1) % (1 << CW);
            m_busy = 0;
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".rf_we"},    32'(rf_we),        32'(m_rf_we));
        check({tag, ".rf_waddr"}, 32'(rf_waddr),     m_waddr);
        check({tag, ".rf_wdata"}, rf_wdata,          m_wdata);
        check({tag, ".count"},    32'(retire_count), m_cnt);
        check({tag, ".in_ready"}, 32'(in_ready),     32'(!m_busy));
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        compare_model(tag);
    endtask

    task automatic idle_inputs();
        flush = 0; in_valid = 0; result_set = 0; alu_result = 0; pc_plus4 = 0; csr_data = 0;
        load_funct3 = 0; rd = 0; reg_write = 0; mem_rvalid = 0; mem_rdata = 0;
    endtask

    // Issue a load to x9, return the response after three idle cycles, then check the extended data.
    task automatic do_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] data,
                           input logic [31:0] exp, input string tag);
        in_valid = 1; result_set = 2'b01; alu_result = {30'h0000_1000, off}; rd = 9; reg_write = 1;
        load_funct3 = f3;
        step({tag, ".acc"});
        in_valid = 0;
        for (int i = 0; i < 3; i++) begin
            step({tag, ".wait"});
            check({tag, ".in_ready_wait"}, 32'(in_ready), 32'd0);
        end
        mem_rvalid = 1; mem_rdata = data;
        step({tag, ".resp"});
        mem_rvalid = 0;
        check({tag, ".we"},   32'(rf_we), 32'd1);
        check({tag, ".data"}, rf_wdata,   exp);
    endtask

    initial begin
        logic [CW-1:0] cnt_before;
        n_vec = 0;
        n_err = 0;
        idle_inputs();
        model_reset();
        rst_n = 0;
        #12;
        check("reset.rf_we",    32'(rf_we),        32'd0);
        check("reset.rf_waddr", 32'(rf_waddr),     32'd0);
        check("reset.rf_wdata", rf_wdata,          32'd0);
        check("reset.count",    32'(retire_count), 32'd0);
        check("reset.in_ready", 32'(in_ready),     32'd1);
        rst_n = 1;

        // Back-to-back non-load ops, including x0 and reg_write=0 cases that must hold the port.
        vecs[0] = '{2'b00, 32'h0000_1234, 32'h0,         32'h0,         5'd5,  1'b1, 1'b1, 5'd5,  32'h0000_1234};
        vecs[1] = '{2'b10, 32'h0,         32'h0000_0104, 32'h0,         5'd1,  1'b1, 1'b1, 5'd1,  32'h0000_0104};
        vecs[2] = '{2'b11, 32'h0,         32'h0,         32'hDEAD_BEEF, 5'd2,  1'b1, 1'b1, 5'd2,  32'hDEAD_BEEF};
        vecs[3] = '{2'b00, 32'h0000_0055, 32'h0,         32'h0,         5'd0,  1'b1, 1'b0, 5'd2,  32'hDEAD_BEEF};
        vecs[4] = '{2'b00, 32'h0000_0077, 32'h0,         32'h0,         5'd7,  1'b0, 1'b0, 5'd2,  32'hDEAD_BEEF};
        vecs[5] = '{2'b10, 32'h0,         32'hFFFF_FFFC, 32'h0,         5'd31, 1'b1, 1'b1, 5'd31, 32'hFFFF_FFFC};
        for (int i = 0; i < 6; i++) begin
            in_valid = 1; result_set = vecs[i].rs; alu_result = vecs[i].alu; pc_plus4 = vecs[i].pc4;
            csr_data = vecs[i].csr; rd = vecs[i].rdi; reg_write = vecs[i].rw;
            model_step();
            @(posedge clk);
            #1;
            check($sformatf("vec%0d.we", i),    32'(rf_we),        32'(vecs[i].exp_we));
            check($sformatf("vec%0d.waddr", i), 32'(rf_waddr),     32'(vecs[i].exp_waddr));
            check($sformatf("vec%0d.wdata", i), rf_wdata,          vecs[i].exp_wdata);
            check($sformatf("vec%0d.count", i), 32'(retire_count), 32'(i + 1));
            check($sformatf("vec%0d.ready", i), 32'(in_ready),     32'd1);
        end
        idle_inputs();
        step("idle_after_vec");
        check("pulse_single", 32'(rf_we), 32'd0);

        do_load(3'b000, 2'd3, 32'h80FF_0000, 32'hFFFF_FF80, "lb");
        do_load(3'b100, 2'd3, 32'h80FF_0000, 32'h0000_0080, "lbu");
        do_load(3'b101, 2'd2, 32'h80FF_0000, 32'h0000_80FF, "lhu");
        do_load(3'b001, 2'd2, 32'h80FF_0000, 32'hFFFF_80FF, "lh");
        do_load(3'b010, 2'd1, 32'h80FF_0000, 32'h80FF_0000, "lw");

        // Flush and response in the same cycle: flush wins.
        in_valid = 1; result_set = 2'b01; rd = 4; reg_write = 1; load_funct3 = 3'b010;
        step("fl.acc");
        idle_inputs();
        cnt_before = retire_count;
        flush = 1; mem_rvalid = 1; mem_rdata = 32'h1111_2222;
        step("fl.resp");
        check("fl.we",    32'(rf_we),        32'd0);
        check("fl.count", 32'(retire_count), 32'(cnt_before));
        check("fl.ready", 32'(in_ready),     32'd1);
        idle_inputs();

        // Reset pulse while a load is pending; the late response must be ignored.
        in_valid = 1; result_set = 2'b01; rd = 6; reg_write = 1;
        step("rst.acc");
        idle_inputs();
        rst_n = 0;
        #2;
        check("rst.rf_we",    32'(rf_we),        32'd0);
        check("rst.rf_waddr", 32'(rf_waddr),     32'd0);
        check("rst.rf_wdata", rf_wdata,          32'd0);
        check("rst.count",    32'(retire_count), 32'd0);
        check("rst.ready",    32'(in_ready),     32'd1);
        #2;
        rst_n = 1;
        model_reset();
        mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
        step("rst.late_rvalid");
        check("rst.late_we", 32'(rf_we), 32'd0);
        idle_inputs();

        // Counter wrap: 15 retirements reach the maximum, one more wraps to zero.
        in_valid = 1; result_set = 2'b00; rd = 3; reg_write = 1;
        for (int i = 0; i < 15; i++) begin
            alu_result = 32'(i);
            step("wrap.fill");
        end
        check("wrap.max", 32'(retire_count), 32'd15);
        step("wrap.last");
        check("wrap.zero", 32'(retire_count), 32'd0);
        idle_inputs();

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            result_set  = 2'($urandom_range(0, 3));
            flush       = ($urandom_range(0, 7) == 0);
            mem_rvalid  = ($urandom_range(0, 2) == 0);
            mem_rdata   = $urandom;
            alu_result  = $urandom;
            pc_plus4    = $urandom;
            csr_data    = $urandom;
            load_funct3 = 3'($urandom_range(0, 7));
            rd          = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            reg_write   = ($urandom_range(0, 4) != 0);
            step("rand");
        end
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
